// File: rtl/gat_pkg.sv
// Shared types and width/offset helpers for the coefficient gather stage.
// The slot-offset function is the single definition of the output word layout.
package gat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_SEND   = 2'd2
    } gat_state_e;

    localparam int GAT_DATA_WIDTH = 8;
    localparam int GAT_MAX_NODES  = 168;

    function automatic int num_node_width(input int max_nodes);
        return $clog2(max_nodes);
    endfunction

    function automatic int softmax_width(input int max_nodes, input int data_width);
        return max_nodes * data_width + num_node_width(max_nodes);
    endfunction

    // LSB of slot k inside the softmax word; the count field occupies the bottom bits.
    function automatic int slot_lo(input int k, input int data_width, input int nn_width);
        return nn_width + k * data_width;
    endfunction

endpackage

// File: rtl/coef_gather.sv
// Pops a node count and that many coefficients from two FWFT FIFOs and presents
// them as one zero-padded vector to the softmax stage over valid/ready.
module coef_gather
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH     = GAT_DATA_WIDTH,
    parameter int MAX_NODES      = GAT_MAX_NODES,
    parameter int NUM_NODE_WIDTH = num_node_width(MAX_NODES),
    parameter int SOFTMAX_WIDTH  = softmax_width(MAX_NODES, DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
    input  logic                      coef_ff_empty,
    output logic                      coef_ff_rd_vld,
    input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
    input  logic                      num_node_ff_empty,
    output logic                      num_node_ff_rd_vld,
    output logic [SOFTMAX_WIDTH-1:0]  sm_data_o,
    output logic                      sm_vld_o,
    input  logic                      sm_rdy_i,
    output logic                      err_o
);

    // MAX_NODES is not a power of two, so it always fits in the count width.
    localparam logic [NUM_NODE_WIDTH-1:0] MAX_N = NUM_NODE_WIDTH'(MAX_NODES);

    gat_state_e                r_state;
    logic [NUM_NODE_WIDTH-1:0] r_n;
    logic [NUM_NODE_WIDTH-1:0] r_cnt;
    logic [NUM_NODE_WIDTH-1:0] r_cnt_field;
    logic [DATA_WIDTH-1:0]     r_slot [MAX_NODES];
    logic                      r_vld;
    logic                      r_err;

    logic                      w_node_pop;
    logic                      w_coef_pop;
    logic                      w_in_range;
    logic                      w_last;
    logic                      w_hs;
    logic [SOFTMAX_WIDTH-1:0]  w_sm_data;

    // Pops are combinational so the FWFT head is consumed in the cycle it is used.
    assign w_node_pop = !rst && (r_state == ST_IDLE)   && !num_node_ff_empty;
    assign w_coef_pop = !rst && (r_state == ST_GATHER) && !coef_ff_empty;
    assign w_in_range = (r_cnt < MAX_N);
    assign w_last     = (r_cnt == (r_n - NUM_NODE_WIDTH'(1)));
    assign w_hs       = r_vld && sm_rdy_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_n         <= '0;
            r_cnt       <= '0;
            r_cnt_field <= '0;
            r_vld       <= 1'b0;
            r_err       <= 1'b0;
            for (int k = 0; k < MAX_NODES; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_node_pop) begin
                        r_n         <= num_node_ff_dout;
                        r_cnt       <= '0;
                        r_cnt_field <= (num_node_ff_dout > MAX_N) ? MAX_N : num_node_ff_dout;
                        for (int k = 0; k < MAX_NODES; k++) begin
                            r_slot[k] <= '0;
                        end
                        if (num_node_ff_dout == '0) begin
                            r_state <= ST_SEND;
                            r_vld   <= 1'b1;
                        end else begin
                            r_state <= ST_GATHER;
                        end
                    end
                end
                ST_GATHER: begin
                    if (w_coef_pop) begin
                        // Words past the last slot are still popped to keep the FIFO aligned.
                        for (int k = 0; k < MAX_NODES; k++) begin
                            if (r_cnt == NUM_NODE_WIDTH'(k)) begin
                                r_slot[k] <= coef_ff_dout;
                            end
                        end
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                        r_cnt <= r_cnt + NUM_NODE_WIDTH'(1);
                        if (w_last) begin
                            r_state <= ST_SEND;
                            r_vld   <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_vld   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_sm_data = '0;
        w_sm_data[NUM_NODE_WIDTH-1:0] = r_cnt_field;
        for (int k = 0; k < MAX_NODES; k++) begin
            w_sm_data[slot_lo(k, DATA_WIDTH, NUM_NODE_WIDTH) +: DATA_WIDTH] = r_slot[k];
        end
    end

    assign coef_ff_rd_vld     = w_coef_pop;
    assign num_node_ff_rd_vld = w_node_pop;
    assign sm_data_o          = w_sm_data;
    assign sm_vld_o           = r_vld;
    assign err_o              = r_err;

endmodule

// File: tb/tb_coef_gather.sv
// Scoreboard bench for coef_gather: FWFT FIFO models feed the DUT, expected
// vectors are built from the subgraph rules and checked by a separate monitor.
module tb_coef_gather;
    import gat_pkg::*;

    localparam int DW = GAT_DATA_WIDTH;
    localparam int MN = GAT_MAX_NODES;
    localparam int NW = num_node_width(MN);
    localparam int SW = softmax_width(MN, DW);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] coef_ff_dout;
    logic          coef_ff_empty;
    logic          coef_ff_rd_vld;
    logic [NW-1:0] num_node_ff_dout;
    logic          num_node_ff_empty;
    logic          num_node_ff_rd_vld;
    logic [SW-1:0] sm_data_o;
    logic          sm_vld_o;
    logic          sm_rdy_i;
    logic          err_o;

    always #5 clk = ~clk;

    coef_gather dut (
        .clk               (clk),
        .rst               (rst),
        .coef_ff_dout      (coef_ff_dout),
        .coef_ff_empty     (coef_ff_empty),
        .coef_ff_rd_vld    (coef_ff_rd_vld),
        .num_node_ff_dout  (num_node_ff_dout),
        .num_node_ff_empty (num_node_ff_empty),
        .num_node_ff_rd_vld(num_node_ff_rd_vld),
        .sm_data_o         (sm_data_o),
        .sm_vld_o          (sm_vld_o),
        .sm_rdy_i          (sm_rdy_i),
        .err_o             (err_o)
    );

    typedef struct {
        logic [SW-1:0] vec;
        int            pops;
        int            lat;
        logic          err;
        bit            b2b;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] cq[$];
    logic [NW-1:0] nq[$];
    logic [DW-1:0] fixed_q[$];

    bit coef_hold = 0;
    bit rand_drv  = 0;
    bit err_model = 0;
    bit chk_b2b   = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int node_pop_edge = 0;
    int sg_pops = 0;
    int last_hs_edge = 0;

    task automatic upd_fifo();
        coef_ff_empty     = (cq.size() == 0) || coef_hold;
        coef_ff_dout      = (cq.size() > 0) ? cq[0] : '0;
        num_node_ff_empty = (nq.size() == 0);
        num_node_ff_dout  = (nq.size() > 0) ? nq[0] : '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (act[NW-1:0] !== exp[NW-1:0]) begin
                $display("FAIL %s: count field got %0d, expected %0d", name, act[NW-1:0], exp[NW-1:0]);
            end else begin
                for (int k = 0; k < MN; k++) begin
                    if (act[slot_lo(k, DW, NW) +: DW] !== exp[slot_lo(k, DW, NW) +: DW]) begin
                        $display("FAIL %s: slot %0d got %02h, expected %02h", name, k,
                                 act[slot_lo(k, DW, NW) +: DW], exp[slot_lo(k, DW, NW) +: DW]);
                        break;
                    end
                end
            end
        end
    endtask

    // Reference: the first min(n, MAX) coefficients in order, zeros elsewhere.
    function automatic logic [SW-1:0] build_vec(input int n, input logic [DW-1:0] c[$]);
        int            m = (n > MN) ? MN : n;
        logic [SW-1:0] v = '0;
        v[NW-1:0] = m[NW-1:0];
        for (int k = 0; k < m; k++) begin
            v[slot_lo(k, DW, NW) +: DW] = c[k];
        end
        return v;
    endfunction

    task automatic issue(input int n, input int lat, input bit b2b);
        logic [DW-1:0] c[$];
        logic [DW-1:0] v;
        exp_t          e;
        for (int i = 0; i < n; i++) begin
            v = (i < fixed_q.size()) ? fixed_q[i] : DW'($urandom_range(0, 255));
            c.push_back(v);
            cq.push_back(v);
        end
        if (n > MN) err_model = 1;
        e.vec  = build_vec(n, c);
        e.pops = n;
        e.lat  = lat;
        e.err  = err_model;
        e.b2b  = b2b;
        exp_q.push_back(e);
        nq.push_back(n[NW-1:0]);
        upd_fifo();
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (sg_pops != target && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        if (sg_pops != target) chk("wait_pops_timeout", sg_pops, target);
    endtask

    // FIFO models: pops are sampled mid-cycle and applied just after the edge.
    initial begin
        bit pc;
        bit pn;
        pc = 0;
        pn = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pc && cq.size() > 0) begin
                void'(cq.pop_front());
                sg_pops++;
            end
            if (pn && nq.size() > 0) begin
                void'(nq.pop_front());
                if (chk_b2b) begin
                    chk("b2b_node_pop_gap", cyc - last_hs_edge, 1);
                    chk_b2b = 0;
                end
                node_pop_edge = cyc;
                sg_pops = 0;
            end
            upd_fifo();
            @(negedge clk);
            pc = coef_ff_rd_vld;
            pn = num_node_ff_rd_vld;
            if (pc) chk("coef_pop_while_empty", coef_ff_empty, 0);
            if (pn) chk("node_pop_while_empty", num_node_ff_empty, 0);
        end
    end

    // Monitor: latency on valid rise, stability while stalled, contents at handshake.
    initial begin
        exp_t          e;
        bit            prev_vld;
        bit            prev_hs;
        logic [SW-1:0] prev_data;
        prev_vld  = 0;
        prev_hs   = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 0;
                prev_hs  = 0;
            end else begin
                if (sm_vld_o && prev_vld && !prev_hs) chk_vec("hold_stable", sm_data_o, prev_data);
                if (sm_vld_o && !prev_vld) begin
                    if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                    else if (exp_q[0].lat >= 0) chk("valid_latency", cyc + 1 - node_pop_edge, exp_q[0].lat);
                end
                if (sm_vld_o && sm_rdy_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_handshake", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_vec("vector", sm_data_o, e.vec);
                        chk("coef_pops", sg_pops, e.pops);
                        chk("err_o", err_o, e.err);
                        last_hs_edge = cyc + 1;
                        if (e.b2b) chk_b2b = 1;
                    end
                end
                prev_vld  = sm_vld_o;
                prev_data = sm_data_o;
                prev_hs   = sm_vld_o && sm_rdy_i;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_drv) begin
                sm_rdy_i  = ($urandom_range(0, 2) != 0);
                coef_hold = ($urandom_range(0, 3) == 0);
                upd_fifo();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst      = 1'b1;
        sm_rdy_i = 1'b1;
        upd_fifo();

        // n=3 preloaded during reset; no pop may happen while rst is high
        fixed_q = '{8'h05, 8'h7F, 8'h00};
        issue(3, 4, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_node_rd_vld", num_node_ff_rd_vld, 0);
        chk("rst_coef_rd_vld", coef_ff_rd_vld, 0);
        chk("rst_sm_vld", sm_vld_o, 0);
        chk("rst_err", err_o, 0);
        chk_vec("rst_sm_data", sm_data_o, '0);
        @(posedge clk); #2;
        rst = 1'b0;
        wait_done(50);

        // n=0: immediate send, no coefficient pops
        fixed_q.delete();
        issue(0, 1, 0);
        wait_done(20);

        // n=4 with the coefficient FIFO empty for 5 cycles after the 2nd pop
        issue(4, 10, 0);
        wait_pops(2, 20);
        coef_hold = 1;
        upd_fifo();
        repeat (5) @(posedge clk);
        #2;
        coef_hold = 0;
        upd_fifo();
        wait_done(40);

        // n=2 stalled 3 cycles by the consumer, then a full n=168 subgraph
        sm_rdy_i = 1'b0;
        issue(2, 3, 1);
        issue(168, 169, 0);
        begin
            int k = 0;
            while (!sm_vld_o && k < 20) begin
                @(posedge clk); #2;
                k++;
            end
            chk("stall_valid_seen", sm_vld_o, 1);
        end
        repeat (3) @(posedge clk);
        #2;
        sm_rdy_i = 1'b1;
        wait_done(400);

        // overlong subgraph: extra words discarded, sticky error
        issue(170, 171, 0);
        issue(1, 2, 0);
        wait_done(500);
        chk("err_sticky", err_o, 1);

        // reset in GATHER after 2 of 5 pops
        issue(5, 6, 0);
        wait_pops(2, 20);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cycle_no_coef_pop", coef_ff_rd_vld, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        cq.delete();
        nq.delete();
        exp_q.delete();
        err_model = 0;
        upd_fifo();
        @(negedge clk);
        chk("post_rst_vld", sm_vld_o, 0);
        chk("post_rst_err", err_o, 0);
        chk("post_rst_coef_rd", coef_ff_rd_vld, 0);
        chk_vec("post_rst_data", sm_data_o, '0);
        @(posedge clk); #2;
        issue(3, 4, 0);
        wait_done(30);

        // randomized subgraphs with random consumer stalls and FIFO bubbles
        rand_drv = 1;
        for (int i = 0; i < 12; i++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(160, 175) : $urandom_range(0, 24);
            issue(n, -1, 0);
        end
        wait_done(4000);
        rand_drv = 0;
        @(posedge clk); #3;
        sm_rdy_i  = 1'b1;
        coef_hold = 0;
        upd_fifo();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
